// File: rtl/text_cursor_ctrl.sv
// Write-side controller for the VGA text-mode character RAM.
// Tracks the cursor and sequences char, erase, line-clear and screen-clear writes.
module text_cursor_ctrl #(
  parameter int          COLS   = 71,
  parameter int          ROWS   = 30,
  parameter int          ADDR_W = 12,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              clr_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_wdata,
  output logic [4:0]        cur_row,
  output logic [6:0]        cur_col,
  output logic              busy
);

  localparam int TOTAL = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE,
    CLR_LINE,
    CLR_ALL
  } state_t;

  state_t state, state_d;

  logic              pend, pend_d;
  logic [4:0]        row_d;
  logic [6:0]        col_d;
  logic              we_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [7:0]        wdata_d;
  logic [ADDR_W-1:0] sweep, sweep_d;
  logic [ADDR_W-1:0] last, last_d;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] nl_base;
  logic [4:0]        nl_row;
  logic              nl;
  logic              accept;
  logic              printable;
  logic              is_cr;
  logic              is_bs;

  assign cur_addr  = ADDR_W'(cur_row) * ADDR_W'(COLS)
                   + ADDR_W'(cur_col);
  assign nl_row    = (cur_row == 5'(ROWS - 1)) ? 5'd0
                   : cur_row + 5'd1;
  assign nl_base   = ADDR_W'(nl_row) * ADDR_W'(COLS);

  assign in_ready  = (state == IDLE) && !pend;
  assign busy      = (state != IDLE) || pend;
  // A same-cycle clear request takes priority over the byte.
  assign accept    = in_valid && in_ready && !clr_req;

  assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign is_cr     = (in_data == 8'h0D);
  assign is_bs     = (in_data == 8'h08);

  always_comb begin
    state_d = state;
    pend_d  = pend | clr_req;
    row_d   = cur_row;
    col_d   = cur_col;
    we_d    = 1'b0;
    waddr_d = ram_waddr;
    wdata_d = ram_wdata;
    sweep_d = sweep;
    last_d  = last;
    nl      = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_req || pend) begin
          state_d = CLR_ALL;
          pend_d  = 1'b0;
          row_d   = 5'd0;
          col_d   = 7'd0;
          sweep_d = '0;
          last_d  = ADDR_W'(TOTAL - 1);
        end else if (accept) begin
          unique case (1'b1)
            printable: begin
              we_d    = 1'b1;
              waddr_d = cur_addr;
              wdata_d = in_data;
              if (cur_col == 7'(COLS - 1))
                nl = 1'b1;
              else
                col_d = cur_col + 7'd1;
            end
            is_cr: nl = 1'b1;
            is_bs: begin
              // Previous cell is always cur_addr-1, even across rows.
              if (cur_col != 7'd0 || cur_row != 5'd0) begin
                we_d    = 1'b1;
                waddr_d = cur_addr - ADDR_W'(1);
                wdata_d = BLANK;
                if (cur_col != 7'd0) begin
                  col_d = cur_col - 7'd1;
                end else begin
                  row_d = cur_row - 5'd1;
                  col_d = 7'(COLS - 1);
                end
              end
            end
            default: ;
          endcase
        end
      end
      CLR_LINE, CLR_ALL: begin
        we_d    = 1'b1;
        waddr_d = sweep;
        wdata_d = BLANK;
        sweep_d = sweep + ADDR_W'(1);
        if (sweep == last)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (nl) begin
      row_d   = nl_row;
      col_d   = 7'd0;
      state_d = CLR_LINE;
      sweep_d = nl_base;
      last_d  = nl_base + ADDR_W'(COLS - 1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      pend      <= 1'b0;
      cur_row   <= 5'd0;
      cur_col   <= 7'd0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= 8'd0;
      sweep     <= '0;
      last      <= '0;
    end else begin
      state     <= state_d;
      pend      <= pend_d;
      cur_row   <= row_d;
      cur_col   <= col_d;
      ram_we    <= we_d;
      ram_waddr <= waddr_d;
      ram_wdata <= wdata_d;
      sweep     <= sweep_d;
      last      <= last_d;
    end
  end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Bench for text_cursor_ctrl: directed scenarios plus random traffic
// checked cycle by cycle against a queue-based reference model.
module tb_text_cursor_ctrl;

  localparam int COLS   = 71;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;
  localparam int TOTAL  = COLS * ROWS;
  localparam logic [7:0] BLANK = 8'h20;

  logic              clk = 1'b0;
  logic              clrn;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              clr_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic [4:0]        cur_row;
  logic [6:0]        cur_col;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // reference model: cursor, pending clear, queue of future writes
  int         mr, mc;
  bit         m_pend;
  int         aq[$];
  logic [7:0] dq[$];
  bit         exp_we;
  int         ea;
  logic [7:0] ed;

  text_cursor_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLANK(BLANK)
  ) dut (
    .clk(clk), .clrn(clrn),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .clr_req(clr_req),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    aq.delete();
    dq.delete();
    mr = 0;
    mc = 0;
    m_pend = 0;
  endtask

  task automatic push_line(input int r);
    for (int k = 0; k < COLS; k++) begin
      aq.push_back(r * COLS + k);
      dq.push_back(BLANK);
    end
  endtask

  task automatic newline();
    mr = (mr + 1) % ROWS;
    mc = 0;
    push_line(mr);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_we = 1;
      ea = mr * COLS + mc;
      ed = b;
      mc++;
      if (mc == COLS) newline();
    end else if (b == 8'h0D) begin
      newline();
    end else if (b == 8'h08) begin
      if (mc > 0) begin
        mc--;
        exp_we = 1; ea = mr * COLS + mc; ed = BLANK;
      end else if (mr > 0) begin
        mr--;
        mc = COLS - 1;
        exp_we = 1; ea = mr * COLS + mc; ed = BLANK;
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d,
                      input logic c, output bit acc);
    bit idle;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clr_req  = c;
    #1;
    idle = (aq.size() == 0);
    chk("in_ready", in_ready, idle && !m_pend);
    chk("busy", busy, !idle || m_pend);
    acc = 0;
    exp_we = 0;
    if (!idle) begin
      exp_we = 1;
      ea = aq.pop_front();
      ed = dq.pop_front();
      if (c) m_pend = 1;
    end else if (c || m_pend) begin
      m_pend = 0;
      mr = 0;
      mc = 0;
      for (int k = 0; k < TOTAL; k++) begin
        aq.push_back(k);
        dq.push_back(BLANK);
      end
    end else if (v) begin
      acc = 1;
      model_byte(d);
    end
    @(posedge clk);
    #1;
    chk("ram_we", ram_we, exp_we);
    if (exp_we) begin
      chk("ram_waddr", ram_waddr, ea);
      chk("ram_wdata", ram_wdata, ed);
    end
    chk("cur_row", cur_row, mr);
    chk("cur_col", cur_col, mc);
  endtask

  task automatic send(input logic [7:0] b);
    bit a;
    int n;
    a = 0;
    n = 0;
    while (!a && n < 5000) begin
      step(1'b1, b, 1'b0, a);
      n++;
    end
    chk("send_timeout", a, 1);
  endtask

  task automatic wait_idle();
    bit a;
    int n;
    n = 0;
    while (!(aq.size() == 0 && !m_pend) && n < 5000) begin
      step(1'b0, 8'h00, 1'b0, a);
      n++;
    end
    chk("idle_timeout", (aq.size() == 0 && !m_pend), 1);
  endtask

  initial begin
    bit a;
    int sel;
    logic [7:0] b;

    clrn = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    clr_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", ram_we, 0);
    chk("rst_waddr", ram_waddr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_row", cur_row, 0);
    chk("rst_col", cur_col, 0);
    @(negedge clk);
    clrn = 1'b1;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);

    // 'A','B' back to back
    send(8'h41);
    send(8'h42);
    chk("ab_row", cur_row, 0);
    chk("ab_col", cur_col, 2);

    // home, then a full row of 'x' wraps and sweeps row 1
    step(1'b0, 8'h00, 1'b1, a);
    wait_idle();
    for (int i = 0; i < COLS; i++) send(8'h78);
    wait_idle();

    // CR from (3,5)
    send(8'h0D);
    send(8'h0D);
    for (int i = 0; i < 5; i++) send(8'h61);
    send(8'h0D);
    wait_idle();
    chk("cr_row", cur_row, 4);

    // backspace across a row boundary, then at origin
    step(1'b0, 8'h00, 1'b1, a);
    wait_idle();
    send(8'h0D);
    send(8'h0D);
    wait_idle();
    send(8'h08);
    chk("bs_col", cur_col, COLS - 1);
    step(1'b0, 8'h00, 1'b1, a);
    wait_idle();
    send(8'h08);
    send(8'h01);
    send(8'h7F);

    // clear wins over a same-cycle byte
    step(1'b1, 8'h51, 1'b1, a);
    chk("clr_prio_acc", a, 0);
    wait_idle();

    // wrap from last row back to row 0
    for (int i = 0; i < ROWS - 1; i++) send(8'h0D);
    wait_idle();
    chk("last_row", cur_row, ROWS - 1);
    send(8'h0D);
    wait_idle();
    chk("wrap_row", cur_row, 0);

    // clear request during a line sweep, duplicated
    send(8'h0D);
    step(1'b0, 8'h00, 1'b0, a);
    step(1'b0, 8'h00, 1'b1, a);
    step(1'b0, 8'h00, 1'b1, a);
    wait_idle();

    // reset in the middle of a full-screen sweep
    send(8'h55);
    step(1'b0, 8'h00, 1'b1, a);
    repeat (100) step(1'b0, 8'h00, 1'b0, a);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_row", cur_row, 0);
    chk("mid_rst_col", cur_col, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    clrn = 1'b1;
    model_reset();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) b = 8'($urandom_range(32, 126));
      else if (sel == 6) b = 8'h0D;
      else if (sel == 7 || sel == 9) b = 8'h08;
      else b = 8'($urandom_range(127, 255));
      step(1'($urandom_range(0, 3) != 0), b,
           1'($urandom_range(0, 499) == 0), a);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
